spart_bus_if: RTL and testbench
===============================

# spart_bus_if

Processor-side bus interface for the SPART serial port; sits directly upstream of the SPART transceiver core. It decodes a 2-bit register bus, buffers outgoing bytes in a TX FIFO, and feeds them one at a time to the transceiver. It also captures received bytes into an RX FIFO and holds the 16-bit baud divisor. It provides status, flow-control and error flags to the processor.

## Interface
Parameters:
- FIFO_DEPTH, 8 — entries per FIFO; power of two, 2..8.
- DEFAULT_BAUD, 16'd325 — baud divisor loaded at reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- iocs  in  1  register access strobe, one cycle per access
- iorw  in  1  1 = read, 0 = write
- ioaddr  in  2  00 data, 01 status, 10 divisor low, 11 divisor high
- wdata  in  8  write data
- rdata  out  8  registered read data
- tbr  out  1  TX FIFO not full
- rda  out  1  RX FIFO not empty
- rx_overrun  out  1  sticky: received byte dropped because the RX FIFO was full
- tx_overflow  out  1  sticky: processor write dropped because the TX FIFO was full
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle launch pulse to the transceiver
- tx_busy  in  1  transceiver is shifting a frame
- rx_data  in  8  received byte
- rx_done  in  1  one-cycle pulse; rx_data is valid in the same cycle
- baud  out  16  divisor, {div_high, div_low}

## Operation
- Write to 00: push wdata into the TX FIFO. If the FIFO is full, drop the byte and set tx_overflow.
- Read of 00: pop the RX FIFO head into rdata. If the RX FIFO is empty, return 8'h00 and leave the pointers unchanged.
- Read of 01: rdata = {tx_free[3:0], rx_count[3:0]}. Both counts range 0..FIFO_DEPTH.
- Write to 01: clear rx_overrun and tx_overflow. If a set event occurs in the same cycle, the set wins.
- Read/write of 10 and 11: access div_low / div_high. A write updates baud the next cycle.
- rx_done: push rx_data into the RX FIFO. If the FIFO is full, drop the byte and set rx_overrun.
- Simultaneous push and pop on the same FIFO:
  - Both are performed, even when the FIFO is full or empty.
  - On an empty FIFO, the pop returns 8'h00 and only the push takes effect.
- TX FSM states IDLE, START, ARM, WAIT:
  - IDLE → START when the TX FIFO is non-empty.
  - START: tx_start = 1 and tx_data = FIFO head; pop; → ARM.
  - ARM: one cycle, lets tx_busy rise; → WAIT.
  - WAIT → IDLE when tx_busy = 0.
- tx_data holds its value from START until the next START.

## Timing
- Reset values: rdata 0, tbr 1, rda 0, rx_overrun 0, tx_overflow 0, tx_data 0, tx_start 0, baud DEFAULT_BAUD, FIFOs empty, FSM IDLE.
- Read latency: rdata is valid the cycle after the iocs read cycle and holds until the next read.
- tbr and rda are registered flags. They reflect FIFO occupancy one cycle after each push or pop.
- Back-to-back launches are spaced at least 4 cycles apart: START, ARM, ≥1 WAIT, IDLE.
- The first tx_start occurs 2 cycles after the first TX push.
- Reset mid-frame returns everything to reset values immediately. tx_start is never left asserted.
- The FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Counts are one bit wider.

## Structure
- Package spart_pkg holds:
  - the register address constants (ADDR_DATA, ADDR_STATUS, ADDR_DIVL, ADDR_DIVH);
  - the tx_state_t enum;
  - the DEFAULT_BAUD constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) is instantiated twice. It exposes push, pop, din, dout (head, show-ahead), full, empty and count.

## Test plan
- Reset release → baud = 325, tbr = 1, rda = 0, and a status read returns 8'h80 (tx_free 8, rx_count 0).
- Write 8'hA5 to 00 with tx_busy modelled high for 10 cycles after tx_start → tx_start pulses once, 2 cycles after the write, with tx_data = A5. No second pulse occurs.
- 9 writes to 00 with tx_busy held high → tbr = 0 after the 8th write is accepted; the 9th sets tx_overflow. A write to 01 clears it.
- 9 rx_done pulses carrying 8'h01..8'h09 → rx_overrun = 1. Eight reads return 01..08, then a ninth returns 00 with rda = 0.
- Write 8'h1B to 10 and 8'h00 to 11 → baud = 16'h001B the cycle after the second write. Reads back 1B and 00.
- rx_done in the same cycle as a data read on a full RX FIFO → the pop returns the oldest byte, the push is accepted, and rx_overrun stays 0.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART processor bus interface.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIVL   = 2'b10;
  localparam logic [1:0] ADDR_DIVH   = 2'b11;

  localparam logic [15:0] DEFAULT_BAUD = 16'd325;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_ARM,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags and an occupancy count.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; dout is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = empty_q ? '0 : mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/spart_bus_if.sv
// Processor-side register interface for the SPART: TX/RX FIFOs, baud divisor,
// sticky error flags, and the launch FSM that hands TX bytes to the transceiver.
module spart_bus_if #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] DEFAULT_BAUD = spart_pkg::DEFAULT_BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        tbr,
  output logic        rda,
  output logic        rx_overrun,
  output logic        tx_overflow,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [15:0] baud
);

  import spart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_acc, rd_acc;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic [3:0]    tx_free4, rx_count4;

  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    div_low_q, div_low_d, div_high_q, div_high_d;
  logic          rx_overrun_q, rx_overrun_d, tx_overflow_q, tx_overflow_d;
  logic [7:0]    tx_data_q;
  logic          tx_load;
  tx_state_t     state_q, state_d;

  assign wr_acc  = iocs & ~iorw;
  assign rd_acc  = iocs & iorw;
  assign tx_push = wr_acc && (ioaddr == ADDR_DATA);
  assign rx_pop  = rd_acc && (ioaddr == ADDR_DATA);
  assign rx_push = rx_done;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_free4  = 4'(FIFO_DEPTH) - 4'(tx_count);
  assign rx_count4 = 4'(rx_count);

  // Register file; a set event on a sticky flag beats a same-cycle clear.
  always_comb begin
    rdata_d       = rdata_q;
    div_low_d     = div_low_q;
    div_high_d    = div_high_q;
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;

    if (rd_acc) begin
      case (ioaddr)
        ADDR_DATA:   rdata_d = rx_head;
        ADDR_STATUS: rdata_d = {tx_free4, rx_count4};
        ADDR_DIVL:   rdata_d = div_low_q;
        default:     rdata_d = div_high_q;
      endcase
    end

    if (wr_acc) begin
      case (ioaddr)
        ADDR_STATUS: begin
          rx_overrun_d  = 1'b0;
          tx_overflow_d = 1'b0;
        end
        ADDR_DIVL: div_low_d  = wdata;
        ADDR_DIVH: div_high_d = wdata;
        default:   ;
      endcase
    end

    if (tx_push && tx_full && !tx_pop) tx_overflow_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_overrun_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q       <= '0;
      div_low_q     <= DEFAULT_BAUD[7:0];
      div_high_q    <= DEFAULT_BAUD[15:8];
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      div_low_q     <= div_low_d;
      div_high_q    <= div_high_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  // tx_data is captured on entry to START so it is already valid while tx_start is high.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_pop   = 1'b0;
    tx_load  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          state_d = TX_START;
          tx_load = 1'b1;
        end
      end
      TX_START: begin
        tx_start = 1'b1;
        tx_pop   = 1'b1;
        state_d  = TX_ARM;
      end
      TX_ARM:  state_d = TX_WAIT;
      TX_WAIT: if (!tx_busy) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (tx_load) tx_data_q <= tx_head;
    end
  end

  assign rdata       = rdata_q;
  assign tbr         = ~tx_full;
  assign rda         = ~rx_empty;
  assign rx_overrun  = rx_overrun_q;
  assign tx_overflow = tx_overflow_q;
  assign tx_data     = tx_data_q;
  assign baud        = {div_high_q, div_low_q};

endmodule

// File: tb/tb_spart_bus_if.sv
// Scenario bench for spart_bus_if: scoreboard queues for TX launches and RX reads,
// with a transceiver model that holds tx_busy for 10 cycles after each tx_start.
module tb_spart_bus_if;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  wdata, rdata;
  logic        tbr, rda, rx_overrun, tx_overflow;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [15:0] baud;

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  logic       busy_hold;
  logic [4:0] busy_cnt;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                busy_cnt <= 5'd0;
    else if (tx_start)         busy_cnt <= 5'd10;
    else if (busy_cnt != 5'd0) busy_cnt <= busy_cnt - 5'd1;
  end
  assign tx_busy = busy_hold | (busy_cnt != 5'd0);

  spart_bus_if #(.FIFO_DEPTH(DEPTH), .DEFAULT_BAUD(16'd325)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .wdata       (wdata),
    .rdata       (rdata),
    .tbr         (tbr),
    .rda         (rda),
    .rx_overrun  (rx_overrun),
    .tx_overflow (tx_overflow),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .baud        (baud)
  );

  // Bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; wdata = d;
    @(negedge clk);
    iocs = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
    d = rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    if (rx_exp.size() < DEPTH) rx_exp.push_back(d);
    rx_data = d; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; wdata = 8'h00;
    rx_data = 8'h00; rx_done = 1'b0; busy_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (baud !== 16'd325) begin errors++; $display("FAIL reset_baud got=%h want=%h", baud, 16'd325); end
    checks++;
    if ({tbr, rda, rx_overrun, tx_overflow, tx_start} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got=%b want=%b", {tbr, rda, rx_overrun, tx_overflow, tx_start}, 5'b10000);
    end
    checks++;
    if ({rdata, tx_data} !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h want=0000", {rdata, tx_data}); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL reset_status got=%h want=80", d); end
  endtask

  task automatic test_tx_single();
    int pulses = 0;
    int first = -1;
    logic [7:0] e;
    tx_exp.push_back(8'hA5);
    bus_write(2'd0, 8'hA5);
    for (int k = 0; k < 30; k++) begin
      if (tx_start) begin
        if (pulses == 0) first = k;
        pulses++;
        checks++;
        if (tx_exp.size() == 0) begin
          errors++; $display("FAIL single_extra_launch got=%h want=none", tx_data);
        end else begin
          e = tx_exp.pop_front();
          if (tx_data !== e) begin errors++; $display("FAIL single_tx_data got=%h want=%h", tx_data, e); end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL single_pulse_count got=%0d want=1", pulses); end
    checks++;
    if (first != 1) begin errors++; $display("FAIL single_latency got=%0d want=1 (cycles after write cycle: 2)", first); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d, e;
    int pulses = 0;
    int last = -100;
    bit seen = 0;
    busy_hold = 1'b1;
    tx_exp.push_back(8'h30);
    bus_write(2'd0, 8'h30);
    for (int k = 0; k < 10 && !seen; k++) begin
      if (tx_start) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL prime_launch_timeout got=none want=tx_start");
    end else begin
      e = tx_exp.pop_front();
      if (tx_data !== e) begin errors++; $display("FAIL prime_tx_data got=%h want=%h", tx_data, e); end
    end
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) tx_exp.push_back(8'(8'h40 + i));
      bus_write(2'd0, 8'(8'h40 + i));
      if (i == 6) begin
        checks++;
        if (tbr !== 1'b1) begin errors++; $display("FAIL tbr_after_7 got=%b want=1", tbr); end
      end
      if (i == 7) begin
        checks++;
        if ({tbr, tx_overflow} !== 2'b00) begin errors++; $display("FAIL tbr_after_8 got=%b want=00", {tbr, tx_overflow}); end
      end
    end
    checks++;
    if (tx_overflow !== 1'b1) begin errors++; $display("FAIL tx_overflow_set got=%b want=1", tx_overflow); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL status_tx_full got=%h want=00", d); end
    bus_write(2'd1, 8'h00);
    checks++;
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_overflow_clear got=%b want=0", tx_overflow); end
    busy_hold = 1'b0;
    for (int k = 0; k < 250; k++) begin
      if (tx_start) begin
        checks++;
        if (tx_exp.size() == 0) begin
          errors++; $display("FAIL drain_extra_launch got=%h want=none", tx_data);
        end else begin
          e = tx_exp.pop_front();
          if (tx_data !== e) begin errors++; $display("FAIL drain_tx_data got=%h want=%h", tx_data, e); end
        end
        if (pulses > 0) begin
          checks++;
          if (k - last < 4) begin errors++; $display("FAIL launch_spacing got=%0d want>=4", k - last); end
        end
        last = k;
        pulses++;
      end
      @(negedge clk);
    end
    checks++;
    if (tx_exp.size() != 0) begin errors++; $display("FAIL drain_timeout got=%0d left want=0", tx_exp.size()); end
    checks++;
    if (tbr !== 1'b1) begin errors++; $display("FAIL tbr_after_drain got=%b want=1", tbr); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] d, e;
    for (int i = 1; i <= 9; i++) rx_pulse(8'(i));
    checks++;
    if ({rx_overrun, rda} !== 2'b11) begin errors++; $display("FAIL rx_overrun_set got=%b want=11", {rx_overrun, rda}); end
    // Clear and a dropped byte in the same cycle: the set must win.
    rx_data = 8'hEE; rx_done = 1'b1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'd1; wdata = 8'h00;
    @(negedge clk);
    rx_done = 1'b0; iocs = 1'b0;
    checks++;
    if (rx_overrun !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b want=1", rx_overrun); end
    bus_write(2'd1, 8'h00);
    checks++;
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_overrun_clear got=%b want=0", rx_overrun); end
    for (int i = 0; i < 9; i++) begin
      e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
      bus_read(2'd0, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rx_read_%0d got=%h want=%h", i, d, e); end
    end
    checks++;
    if (rda !== 1'b0) begin errors++; $display("FAIL rda_after_drain got=%b want=0", rda); end
  endtask

  task automatic test_baud();
    logic [7:0] d;
    bus_write(2'd2, 8'h1B);
    checks++;
    if (baud !== 16'h011B) begin errors++; $display("FAIL baud_low got=%h want=011B", baud); end
    bus_write(2'd3, 8'h00);
    checks++;
    if (baud !== 16'h001B) begin errors++; $display("FAIL baud_high got=%h want=001B", baud); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 8'h1B) begin errors++; $display("FAIL divl_read got=%h want=1B", d); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL divh_read got=%h want=00", d); end
  endtask

  task automatic test_back_to_back_rx();
    logic [7:0] d, e;
    for (int i = 0; i < DEPTH; i++) rx_pulse(8'(8'h10 + i));
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h88) begin errors++; $display("FAIL status_rx_full got=%h want=88", d); end
    // Read of a full RX FIFO with a byte arriving the same cycle.
    rx_exp.push_back(8'h18);
    e = rx_exp.pop_front();
    rx_data = 8'h18; rx_done = 1'b1;
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
    @(negedge clk);
    rx_done = 1'b0; iocs = 1'b0; iorw = 1'b0;
    d = rdata;
    checks++;
    if (d !== e) begin errors++; $display("FAIL simul_pop got=%h want=%h", d, e); end
    checks++;
    if ({rx_overrun, rda} !== 2'b01) begin errors++; $display("FAIL simul_flags got=%b want=01", {rx_overrun, rda}); end
    for (int i = 0; i < DEPTH; i++) begin
      e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
      bus_read(2'd0, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL simul_drain_%0d got=%h want=%h", i, d, e); end
    end
    checks++;
    if (rda !== 1'b0) begin errors++; $display("FAIL simul_rda_end got=%b want=0", rda); end
  endtask

  task automatic test_reset_midframe();
    bit seen = 0;
    int extra = 0;
    bus_write(2'd0, 8'h77);
    for (int k = 0; k < 10 && !seen; k++) begin
      if (tx_start) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midframe_timeout got=none want=tx_start");
    end else begin
      rst_n = 1'b0;
      #1;
      if ({tx_start, tbr, rda, tx_data, baud} !== {3'b010, 8'h00, 16'd325}) begin
        errors++;
        $display("FAIL midframe_reset got=%b/%h/%h want=010/00/0145", {tx_start, tbr, rda}, tx_data, baud);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tx_exp.delete();
    for (int k = 0; k < 8; k++) begin
      if (tx_start) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL midframe_relaunch got=%0d want=0", extra); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_rx_overrun();
    test_baud();
    test_back_to_back_rx();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
